// File: rtl/three_input_debouncer_pkg.sv
// Shared lab timing constants used to derive default debounce lengths.
package lab_consts;

   localparam int unsigned CLK_FREQ_HZ             = 100_000_000;
   localparam int unsigned DEBOUNCE_MS             = 1;
   localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_FREQ_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/three_input_debouncer_channel.sv
// Single-line conditioner: 2-flop synchroniser, stability counter, and
// registered rise/fall pulses aligned with the committed level.
module debounce_channel
   import lab_consts::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 17
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic dout,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
      $error("debounce_channel: DEBOUNCE_CYCLES must be >= 1");
   end
   if ((64'd1 << CNT_W) < 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
      $error("debounce_channel: CNT_W too narrow for DEBOUNCE_CYCLES");
   end

   logic             s1;
   logic             s2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         cnt  <= '0;
         dout <= 1'b0;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         rise <= 1'b0;
         fall <= 1'b0;
         if (s2 == dout) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // Commit on the same edge as the pulse so both appear together.
            dout <= s2;
            cnt  <= '0;
            rise <= s2;
            fall <= ~s2;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/three_input_debouncer.sv
// Three independent debounced switch channels feeding the NOR gate inputs a/b/c.
module three_input_debouncer
   import lab_consts::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
   parameter int unsigned CNT_W           = 17
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] sw_in,
   output logic [2:0] sw_db,
   output logic [2:0] sw_rise,
   output logic [2:0] sw_fall
);

   for (genvar i = 0; i < 3; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_ch (
         .clk   (clk),
         .rst_n (rst_n),
         .din   (sw_in[i]),
         .dout  (sw_db[i]),
         .rise  (sw_rise[i]),
         .fall  (sw_fall[i])
      );
   end

endmodule
